stream_idct_arbiter: RTL and testbench

Shares one `stream_idct` pipeline between `NUM_REQ` independent 64-bit coefficient streams. The arbiter grants the IDCT input to one requester for a whole 8x8 block at a time, in round-robin order. It records each grant in an in-order tag FIFO, and uses that FIFO to route each result block back to the requester that issued it. It sits between the per-requester DMA streams and the single `stream_idct` instance.

---
 rtl/stream_idct_arbiter.sv | 175 +++++++++++++++++
 tb/tb_stream_idct_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_idct_arbiter.sv
// Round-robin arbiter that shares one IDCT pipeline between NUM_REQ coefficient streams,
// granting a whole block at a time and routing results back in order through a tag FIFO.
// Latency: req->idct_in and idct_out->rsp are combinational; one IDLE cycle between input blocks.
// Backpressure: idct_in_ready flows to the granted requester only; the head requester's rsp_ready
// flows to idct_out_ready (a stalled head blocks all returns); no grant while MAX_INFLIGHT blocks are open.
// Ports: aclk/aresetn; req_* (per-requester in); idct_in_* / idct_out_* (IDCT side);
// rsp_* (per-requester out, shared data); inflight (tag FIFO occupancy); busy.
module stream_idct_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int IN_BEATS     = 32,
  parameter int OUT_BEATS    = 32,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [64*NUM_REQ-1:0]             req_data,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              idct_in_valid,
  output logic [63:0]                       idct_in_data,
  output logic                              idct_in_last,
  input  logic                              idct_in_ready,
  input  logic                              idct_out_valid,
  input  logic [63:0]                       idct_out_data,
  output logic                              idct_out_ready,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [63:0]                       rsp_data,
  output logic                              rsp_last,
  input  logic [NUM_REQ-1:0]                rsp_ready,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                              busy
);

  localparam int TW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam int IW = (IN_BEATS > 1) ? $clog2(IN_BEATS) : 1;
  localparam int OW = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   gnt_q, gnt_d;
  logic [TW-1:0]   prio_q, prio_d;
  logic [IW-1:0]   in_cnt_q, in_cnt_d;
  logic [OW-1:0]   out_cnt_q, out_cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   tag_mem_q [MAX_INFLIGHT];
  logic [TW-1:0]   tag_mem_d [MAX_INFLIGHT];

  logic            win_found;
  logic [TW-1:0]   win_idx;
  logic [TW-1:0]   cand;
  logic [TW-1:0]   head;
  logic            fifo_full, fifo_empty;
  logic            push, pop;
  logic            in_hs, out_hs, in_end, out_end;

  assign fifo_full  = (count_q == CW'(MAX_INFLIGHT));
  assign fifo_empty = (count_q == '0);
  assign head       = tag_mem_q[rd_ptr_q];

  // First valid requester at or after prio, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = TW'((int'(prio_q) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Datapath and handshakes: purely combinational steering.
  always_comb begin
    req_ready      = '0;
    rsp_valid      = '0;
    idct_in_valid  = 1'b0;
    idct_out_ready = 1'b0;
    idct_in_data   = req_data[int'(gnt_q)*64 +: 64];
    rsp_data       = idct_out_data;
    if (state_q == GRANT) begin
      idct_in_valid    = req_valid[gnt_q];
      req_ready[gnt_q] = idct_in_ready;
    end
    if (!fifo_empty) begin
      rsp_valid[head] = idct_out_valid;
      idct_out_ready  = rsp_ready[head];
    end
  end

  assign in_end       = (in_cnt_q == IW'(IN_BEATS - 1));
  assign out_end      = (out_cnt_q == OW'(OUT_BEATS - 1));
  assign idct_in_last = (state_q == GRANT) && in_end;
  // Gated so a one-beat block cannot show rsp_last with nothing outstanding.
  assign rsp_last     = !fifo_empty && out_end;
  assign in_hs        = idct_in_valid && idct_in_ready;
  assign out_hs       = idct_out_valid && idct_out_ready;
  // The full guard is on the registered count, so a same-cycle pop cannot enable a grant.
  assign push         = (state_q == IDLE) && win_found && !fifo_full;
  assign pop          = out_hs && out_end;
  assign inflight     = count_q;
  assign busy         = (state_q == GRANT) || !fifo_empty;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    prio_d    = prio_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    tag_mem_d = tag_mem_q;

    if (push) begin
      state_d             = GRANT;
      gnt_d               = win_idx;
      in_cnt_d            = '0;
      tag_mem_d[wr_ptr_q] = win_idx;
      wr_ptr_d            = (wr_ptr_q == PW'(MAX_INFLIGHT - 1)) ? '0 : wr_ptr_q + 1'b1;
    end else if ((state_q == GRANT) && in_hs) begin
      in_cnt_d = in_cnt_q + 1'b1;
      if (in_end) begin
        state_d = IDLE;
        prio_d  = (gnt_q == TW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
      end
    end

    if (out_hs) begin
      if (out_end) begin
        out_cnt_d = '0;
        rd_ptr_d  = (rd_ptr_q == PW'(MAX_INFLIGHT - 1)) ? '0 : rd_ptr_q + 1'b1;
      end else begin
        out_cnt_d = out_cnt_q + 1'b1;
      end
    end

    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      prio_q    <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tag_mem_q <= '{default: '0};
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      prio_q    <= prio_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tag_mem_q <= tag_mem_d;
    end
  end

endmodule

// File: tb/tb_stream_idct_arbiter.sv
// Directed bench for stream_idct_arbiter with NUM_REQ=2, 32-beat blocks, 4 blocks in flight.
// The bench plays both the requesters and the IDCT (each finished input block returns 32 beats).
module tb_stream_idct_arbiter;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [127:0] req_data;
  logic         idct_in_valid, idct_in_last, idct_in_ready;
  logic         idct_out_valid, idct_out_ready, rsp_last, busy;
  logic [63:0]  idct_in_data, idct_out_data, rsp_data;
  logic [2:0]   inflight;

  stream_idct_arbiter #(.NUM_REQ(2), .IN_BEATS(32), .OUT_BEATS(32), .MAX_INFLIGHT(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .idct_in_valid(idct_in_valid), .idct_in_data(idct_in_data), .idct_in_last(idct_in_last),
    .idct_in_ready(idct_in_ready),
    .idct_out_valid(idct_out_valid), .idct_out_data(idct_out_data), .idct_out_ready(idct_out_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_ready(rsp_ready),
    .inflight(inflight), .busy(busy)
  );

  always #5 aclk = ~aclk;

  int n_chk = 0;
  int n_err = 0;

  // Bench model state
  int in_beat[2];
  int blocks_left[2];
  int pending, out_beat, blk_out, cyc;
  int stall_r, stall_beat, stall_len, stall_cnt;
  int gnt_log[$];
  int rsp_log[$];
  int gnt_cyc[$];
  int pop_cyc[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic stalled(input int r);
    return (r == stall_r) && (blocks_left[r] > 0) && (in_beat[r] == stall_beat) && (stall_cnt < stall_len);
  endfunction

  task automatic drive();
    for (int r = 0; r < 2; r++) begin
      req_valid[r] = (blocks_left[r] > 0) && !stalled(r);
      req_data[64*r +: 64] = {32'(r), 32'(in_beat[r])};
    end
    idct_out_valid = (pending > 0);
    idct_out_data  = {32'(blk_out), 32'(out_beat)};
  endtask

  task automatic clear_model();
    in_beat = '{0, 0};
    blocks_left = '{0, 0};
    pending = 0; out_beat = 0; blk_out = 0; cyc = 0;
    stall_r = -1; stall_beat = 0; stall_len = 0; stall_cnt = 0;
    gnt_log.delete(); rsp_log.delete(); gnt_cyc.delete(); pop_cyc.delete();
    drive();
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    clear_model();
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
  endtask

  // One clock: sample at negedge, advance model after posedge.
  task automatic cycle();
    int hs_r;
    logic o_hs;
    hs_r = -1;
    @(negedge aclk);
    cyc++;
    for (int r = 0; r < 2; r++)
      if (req_valid[r] && req_ready[r]) hs_r = r;
    if (hs_r >= 0) begin
      if (in_beat[hs_r] == 0) begin
        gnt_log.push_back(hs_r);
        gnt_cyc.push_back(cyc);
      end
      check("in_data", idct_in_data, {32'(hs_r), 32'(in_beat[hs_r])});
      check("in_last", 64'(idct_in_last), 64'(in_beat[hs_r] == 31));
    end
    if (stall_r >= 0 && stalled(stall_r)) begin
      check("stall_rdy", 64'(req_ready), 64'(2'b01 << stall_r));
      check("stall_vld", 64'(idct_in_valid), 64'd0);
      stall_cnt++;
    end
    o_hs = idct_out_valid && idct_out_ready;
    if (o_hs) begin
      if (blk_out < gnt_log.size()) begin
        check("rsp_route", 64'(rsp_valid), 64'(2'b01 << gnt_log[blk_out]));
        if (out_beat == 0) rsp_log.push_back(gnt_log[blk_out]);
      end else begin
        check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end
      check("rsp_data", rsp_data, {32'(blk_out), 32'(out_beat)});
      check("rsp_last", 64'(rsp_last), 64'(out_beat == 31));
    end
    @(posedge aclk);
    #1;
    if (hs_r >= 0) begin
      in_beat[hs_r]++;
      if (in_beat[hs_r] == 32) begin
        in_beat[hs_r] = 0;
        blocks_left[hs_r]--;
        pending++;
      end
    end
    if (o_hs) begin
      out_beat++;
      if (out_beat == 32) begin
        out_beat = 0;
        pending--;
        blk_out++;
        pop_cyc.push_back(cyc);
      end
    end
    drive();
  endtask

  task automatic run_cycles(input int n);
    repeat (n) cycle();
  endtask

  task automatic run_until_rsp(input string tag, input int n, input int budget);
    while (rsp_log.size() < n && budget > 0) begin
      cycle();
      budget--;
    end
    // A returned block counts once its final beat has gone.
    while (pending > 0 && budget > 0 && rsp_log.size() == n && out_beat != 0) begin
      cycle();
      budget--;
    end
    check(tag, 64'(rsp_log.size()), 64'(n));
  endtask

  task automatic run_until_gnt(input string tag, input int n, input int budget);
    while (gnt_log.size() < n && budget > 0) begin
      cycle();
      budget--;
    end
    check(tag, 64'(gnt_log.size()), 64'(n));
  endtask

  initial begin
    idct_in_ready = 1'b1;
    rsp_ready     = 2'b11;
    req_valid     = '0;
    req_data      = '0;
    aresetn       = 1'b0;
    clear_model();

    // Reset state
    @(negedge aclk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_in_valid", 64'(idct_in_valid), 64'd0);
    check("rst_in_last", 64'(idct_in_last), 64'd0);
    check("rst_out_ready", 64'(idct_out_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_last", 64'(rsp_last), 64'd0);
    check("rst_inflight", 64'(inflight), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    // Single block from requester 0
    do_reset();
    blocks_left[0] = 1;
    drive();
    run_until_gnt("single_gnt", 1, 10);
    check("single_inflight1", 64'(inflight), 64'd1);
    run_until_rsp("single_done", 1, 200);
    if (gnt_log.size() > 0) check("single_gnt_r", 64'(gnt_log[0]), 64'd0);
    if (rsp_log.size() > 0) check("single_rsp_r", 64'(rsp_log[0]), 64'd0);
    check("single_inflight0", 64'(inflight), 64'd0);
    check("single_busy0", 64'(busy), 64'd0);

    // Round robin, both continuously valid
    do_reset();
    blocks_left = '{2, 2};
    drive();
    run_until_rsp("rr_done", 4, 400);
    for (int i = 0; i < 4; i++) begin
      if (i < gnt_log.size()) check("rr_gnt", 64'(gnt_log[i]), 64'(i % 2));
      if (i < rsp_log.size()) check("rr_rsp", 64'(rsp_log[i]), 64'(i % 2));
    end

    // Inflight limit: results held back, five blocks offered
    do_reset();
    rsp_ready = 2'b00;
    blocks_left = '{2, 3};
    drive();
    run_cycles(200);
    check("lim_grants", 64'(gnt_log.size()), 64'd4);
    check("lim_inflight", 64'(inflight), 64'd4);
    check("lim_busy", 64'(busy), 64'd1);
    rsp_ready = 2'b11;
    run_until_rsp("lim_done", 5, 400);
    if (gnt_cyc.size() > 4 && pop_cyc.size() > 0)
      check("lim_5th_delay", 64'(gnt_cyc[4] - pop_cyc[0]), 64'd2);
    else
      check("lim_5th_seen", 64'(gnt_cyc.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      if (i < rsp_log.size()) check("lim_rsp", 64'(rsp_log[i]), 64'((i == 4) ? 1 : i % 2));

    // Head-of-line blocking: head tag 1 stalled, requester 0 ready
    do_reset();
    rsp_ready = 2'b01;
    blocks_left[1] = 1;
    drive();
    run_until_gnt("hol_gnt1", 1, 10);
    run_cycles(40);
    blocks_left[0] = 1;
    drive();
    run_cycles(50);
    check("hol_out_ready", 64'(idct_out_ready), 64'd0);
    check("hol_rsp_valid", 64'(rsp_valid), 64'b10);
    check("hol_inflight", 64'(inflight), 64'd2);
    check("hol_none_back", 64'(rsp_log.size()), 64'd0);
    rsp_ready = 2'b11;
    run_until_rsp("hol_done", 2, 200);
    if (rsp_log.size() > 1) begin
      check("hol_order0", 64'(rsp_log[0]), 64'd1);
      check("hol_order1", 64'(rsp_log[1]), 64'd0);
    end

    // Requester stall mid-block
    do_reset();
    stall_r = 0; stall_beat = 10; stall_len = 5;
    blocks_left = '{1, 1};
    drive();
    run_until_rsp("stall_done", 2, 300);
    check("stall_cycles", 64'(stall_cnt), 64'd5);
    if (gnt_log.size() > 1) begin
      check("stall_gnt0", 64'(gnt_log[0]), 64'd0);
      check("stall_gnt1", 64'(gnt_log[1]), 64'd1);
    end

    // Reset in the middle of requester 1's block (prio is 1 at that point)
    do_reset();
    blocks_left = '{1, 1};
    drive();
    run_until_gnt("mrst_gnt2", 2, 60);
    for (int i = 0; i < 40 && in_beat[1] != 12; i++) cycle();
    check("mrst_at_beat", 64'(in_beat[1]), 64'd12);
    aresetn = 1'b0;
    #1;
    check("mrst_req_ready", 64'(req_ready), 64'd0);
    check("mrst_in_valid", 64'(idct_in_valid), 64'd0);
    check("mrst_in_last", 64'(idct_in_last), 64'd0);
    check("mrst_out_ready", 64'(idct_out_ready), 64'd0);
    check("mrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mrst_rsp_last", 64'(rsp_last), 64'd0);
    check("mrst_inflight", 64'(inflight), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    do_reset();
    blocks_left = '{1, 1};
    drive();
    run_until_gnt("mrst_regrant", 1, 10);
    if (gnt_log.size() > 0) check("mrst_first_r0", 64'(gnt_log[0]), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
